// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, control-state typedef and accumulate helper for mac_vec_acc
//
// Purpose: default operand/accumulator widths, the packed state of the valid
//          pipeline and element counter, and sat_add(), the per-add accumulate
//          step with overflow detect.
// Macro:   MAC_VEC_SAT_EN - when defined, sat_add() clamps to the ACC_W signed
//          range; when undefined it wraps (two's complement) at ACC_W.
package mac_pkg;

  localparam int A_W_DEF   = 14;
  localparam int B_W_DEF   = 14;
  localparam int ACC_W_DEF = 32;

  // Element counter width; VEC_LEN is limited to 2**CNT_W.
  localparam int CNT_W = 16;

  // Working width of sat_add(); callers sign-extend into it and ACC_W must
  // stay below it so a single add can never overflow the working width.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic             v1;
    logic             v2;
    logic [CNT_W-1:0] cnt;
  } vstate_t;

  typedef struct packed {
    logic signed [SAT_W-1:0] sum;
    logic                    ovf;
  } sat_res_t;

  // acc and p hold values already inside the w-bit signed range, so the exact
  // sum leaves that range exactly when the w-bit add overflows (equal operand
  // signs, differing result sign).
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] acc,
                                       input logic signed [SAT_W-1:0] p,
                                       input int w);
    logic signed [SAT_W-1:0] t;
    logic signed [SAT_W-1:0] mx;
    logic signed [SAT_W-1:0] mn;
    sat_res_t r;
    t  = acc + p;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = ~mx;
    r.ovf = (t > mx) || (t < mn);
`ifdef MAC_VEC_SAT_EN
    r.sum = (t > mx) ? mx : ((t < mn) ? mn : t);
`else
    r.sum = (t <<< (SAT_W - w)) >>> (SAT_W - w);
`endif
    return r;
  endfunction

endpackage

// File: rtl/mac_vec_ctrl.sv
// rtl/mac_vec_ctrl.sv - valid pipeline, element counter and completion control for mac_vec_acc
//
// Ports: clk, reset (async, active-low), clear (sync flush), valid_in;
//        v1 (stage-1 valid), acc_en (product enters the accumulator),
//        first (element 0 of a vector), done (vector completes this edge),
//        valid_out (registered one-cycle completion pulse).
module mac_vec_ctrl
  import mac_pkg::*;
#(
  parameter int VEC_LEN   = 4,
  parameter int PIPE_MULT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic valid_in,
  output logic v1,
  output logic acc_en,
  output logic first,
  output logic done,
  output logic valid_out
);

  vstate_t st;
  logic    pv;

  assign v1     = st.v1;
  assign pv     = (PIPE_MULT != 0) ? st.v2 : st.v1;
  // clear suppresses the accumulate, which also kills a completing element.
  assign acc_en = pv & ~clear;
  assign first  = (st.cnt == '0);
  assign done   = acc_en && (st.cnt == CNT_W'(VEC_LEN - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= done;
      if (clear) begin
        st <= '0;
      end else begin
        st.v1 <= valid_in;
        st.v2 <= (PIPE_MULT != 0) ? st.v1 : 1'b0;
        if (acc_en) st.cnt <= done ? '0 : st.cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mac_vec_acc.sv
// rtl/mac_vec_acc.sv - pipelined signed multiply-accumulate with automatic dot-product framing
//
// Ports: clk; reset (async, active-low); clear (sync flush of current vector);
//        valid_in, a[A_W], b[B_W] (signed operands);
//        f[ACC_W] (signed sum of last completed vector), valid_out (one-cycle
//        pulse when f updates), ovf (overflow in the vector now on f).
// Macro: MAC_VEC_SAT_EN - saturating accumulate when defined, wrapping otherwise.
module mac_vec_acc
  import mac_pkg::*;
#(
  parameter int A_W       = A_W_DEF,
  parameter int B_W       = B_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int VEC_LEN   = 4,
  parameter int PIPE_MULT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    valid_in,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] f,
  output logic                    valid_out,
  output logic                    ovf
);

  if (ACC_W < A_W + B_W || ACC_W >= SAT_W) begin : g_bad_acc_w
    $fatal(1, "mac_vec_acc: ACC_W out of range");
  end
  if (VEC_LEN < 1 || VEC_LEN > 2 ** CNT_W) begin : g_bad_vec_len
    $fatal(1, "mac_vec_acc: VEC_LEN out of range");
  end

  logic                      v1, acc_en, first, done;
  logic signed [A_W-1:0]     a_r;
  logic signed [B_W-1:0]     b_r;
  logic signed [A_W+B_W-1:0] prod;
  logic signed [ACC_W-1:0]   p_ext, p_acc, acc, base;
  logic                      vovf, ovf_tot;
  sat_res_t                  res;
  logic                      unused_sum_hi;

  mac_vec_ctrl #(.VEC_LEN(VEC_LEN), .PIPE_MULT(PIPE_MULT)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .valid_in  (valid_in),
    .v1        (v1),
    .acc_en    (acc_en),
    .first     (first),
    .done      (done),
    .valid_out (valid_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r <= '0;
      b_r <= '0;
    end else if (valid_in) begin
      a_r <= a;
      b_r <= b;
    end
  end

  assign prod  = (A_W+B_W)'(a_r) * (A_W+B_W)'(b_r);
  assign p_ext = ACC_W'(prod);

  if (PIPE_MULT != 0) begin : g_pipe
    logic signed [ACC_W-1:0] p_r;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)  p_r <= '0;
      else if (v1) p_r <= p_ext;
    end
    assign p_acc = p_r;
  end else begin : g_comb
    assign p_acc = p_ext;
  end

  // A new vector starts from zero instead of acc, so the next vector's first
  // product can land in the same cycle the previous one completes.
  assign base = first ? '0 : acc;

  always_comb begin
    res     = sat_add(SAT_W'(base), SAT_W'(p_acc), ACC_W);
    ovf_tot = res.ovf | (~first & vovf);
  end

  // Above ACC_W the sum is only sign extension.
  assign unused_sum_hi = ^res.sum[SAT_W-1:ACC_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc  <= '0;
      vovf <= 1'b0;
      f    <= '0;
      ovf  <= 1'b0;
    end else if (clear) begin
      acc  <= '0;
      vovf <= 1'b0;
    end else if (acc_en) begin
      if (done) begin
        f   <= res.sum[ACC_W-1:0];
        ovf <= ovf_tot;
      end else begin
        acc  <= res.sum[ACC_W-1:0];
        vovf <= ovf_tot;
      end
    end
  end

endmodule

// File: tb/tb_mac_vec_acc.sv
// tb/tb_mac_vec_acc.sv - self-checking bench for mac_vec_acc
module tb_mac_vec_acc;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  longint exp_hold0;

  // u_dut: defaults (ACC_W=32, VEC_LEN=4, PIPE_MULT=1)
  logic clear0 = 1'b0, vin0 = 1'b0;
  logic signed [13:0] a0 = '0, b0 = '0;
  logic signed [31:0] f0;
  logic vo0, ovf0;
  mac_vec_acc u_dut (.clk(clk), .reset(reset), .clear(clear0), .valid_in(vin0),
                     .a(a0), .b(b0), .f(f0), .valid_out(vo0), .ovf(ovf0));

  // u_narrow: ACC_W=28 for overflow behaviour
  logic clear1 = 1'b0, vin1 = 1'b0;
  logic signed [13:0] a1 = '0, b1 = '0;
  logic signed [27:0] f1;
  logic vo1, ovf1;
  mac_vec_acc #(.ACC_W(28)) u_narrow (.clk(clk), .reset(reset), .clear(clear1), .valid_in(vin1),
                                      .a(a1), .b(b1), .f(f1), .valid_out(vo1), .ovf(ovf1));

  // u_single: PIPE_MULT=0, VEC_LEN=1
  logic clear2 = 1'b0, vin2 = 1'b0;
  logic signed [13:0] a2 = '0, b2 = '0;
  logic signed [31:0] f2;
  logic vo2, ovf2;
  mac_vec_acc #(.PIPE_MULT(0), .VEC_LEN(1)) u_single (.clk(clk), .reset(reset), .clear(clear2),
                                                     .valid_in(vin2), .a(a2), .b(b2), .f(f2),
                                                     .valid_out(vo2), .ovf(ovf2));

  longint g0_f[$], g1_f[$], g2_f[$];
  bit     g0_o[$], g1_o[$], g2_o[$];
  int     g0_c[$], g1_c[$], g2_c[$];

  always @(negedge clk) begin
    if (vo0 === 1'b1) begin g0_f.push_back(longint'(f0)); g0_o.push_back(ovf0); g0_c.push_back(cyc); end
    if (vo1 === 1'b1) begin g1_f.push_back(longint'(f1)); g1_o.push_back(ovf1); g1_c.push_back(cyc); end
    if (vo2 === 1'b1) begin g2_f.push_back(longint'(f2)); g2_o.push_back(ovf2); g2_c.push_back(cyc); end
  end

  // Reference: exact integer add, then clamp or wrap into the w-bit range.
  function automatic longint ref_add(input longint s, input longint p, input int w, inout bit o);
    longint mx, t;
    mx = (longint'(1) <<< (w - 1)) - 1;
    t  = s + p;
    if (t > mx || t < -mx - 1) begin
      o = 1'b1;
`ifdef MAC_VEC_SAT_EN
      t = (t > mx) ? mx : -mx - 1;
`else
      t = (t > mx) ? t - (longint'(1) <<< w) : t + (longint'(1) <<< w);
`endif
    end
    return t;
  endfunction

  function automatic int rnd14();
    int r;
    r = int'($urandom_range(0, 16383));
    return (r >= 8192) ? r - 16384 : r;
  endfunction

  // s = index of the posedge that samples the element; the n-th cycle after
  // that edge (counting from 1) is observed with cyc == s + n - 1.
  task automatic put0(input int av, input int bv, output int s);
    @(negedge clk); a0 = av[13:0]; b0 = bv[13:0]; vin0 = 1'b1; s = cyc + 1;
  endtask
  task automatic idle0(input int n);
    repeat (n) begin @(negedge clk); vin0 = 1'b0; end
  endtask
  task automatic put1(input int av, input int bv, output int s);
    @(negedge clk); a1 = av[13:0]; b1 = bv[13:0]; vin1 = 1'b1; s = cyc + 1;
  endtask
  task automatic idle1(input int n);
    repeat (n) begin @(negedge clk); vin1 = 1'b0; end
  endtask
  task automatic put2(input int av, input int bv, output int s);
    @(negedge clk); a2 = av[13:0]; b2 = bv[13:0]; vin2 = 1'b1; s = cyc + 1;
  endtask
  task automatic idle2(input int n);
    repeat (n) begin @(negedge clk); vin2 = 1'b0; end
  endtask

  task automatic clear_caps();
    g0_f.delete(); g0_o.delete(); g0_c.delete();
    g1_f.delete(); g1_o.delete(); g1_c.delete();
    g2_f.delete(); g2_o.delete(); g2_c.delete();
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    checks++; if (f0 !== 32'sd0) begin errors++; $display("FAIL reset_f got %0d exp 0", f0); end
    checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", vo0); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf0); end
    repeat (2) @(negedge clk);
    checks++; if (f1 !== 28'sd0 || vo1 !== 1'b0) begin errors++; $display("FAIL reset_narrow got f=%0d v=%b exp 0/0", f1, vo1); end
    checks++; if (f2 !== 32'sd0 || vo2 !== 1'b0) begin errors++; $display("FAIL reset_single got f=%0d v=%b exp 0/0", f2, vo2); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int s;
    int av[4] = '{1, 2, 3, 4};
    int bv[4] = '{5, 6, 7, 8};
    clear_caps();
    for (int k = 0; k < 4; k++) put0(av[k], bv[k], s);
    idle0(6);
    checks++;
    if (g0_f.size() != 1) begin errors++; $display("FAIL basic_pulses got %0d exp 1", g0_f.size()); end
    else begin
      checks++; if (g0_f[0] !== 70) begin errors++; $display("FAIL basic_f got %0d exp 70", g0_f[0]); end
      checks++; if (g0_o[0] !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", g0_o[0]); end
      checks++; if (g0_c[0] !== s + 2) begin errors++; $display("FAIL basic_latency got %0d exp %0d", g0_c[0], s + 2); end
    end
  endtask

  task automatic test_back_to_back();
    int s4, s8;
    int av[8] = '{1, 1, 1, 1, -3, 0, 5, 7};
    int bv[8] = '{2, 2, 2, 2, 4, 9, -2, 1};
    clear_caps();
    for (int k = 0; k < 4; k++) put0(av[k], bv[k], s4);
    for (int k = 4; k < 8; k++) put0(av[k], bv[k], s8);
    idle0(6);
    checks++;
    if (g0_f.size() != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", g0_f.size()); end
    else begin
      checks++; if (g0_f[0] !== 8) begin errors++; $display("FAIL b2b_f0 got %0d exp 8", g0_f[0]); end
      checks++; if (g0_f[1] !== -15) begin errors++; $display("FAIL b2b_f1 got %0d exp -15", g0_f[1]); end
      checks++; if (g0_c[0] !== s4 + 2 || g0_c[1] !== s8 + 2)
        begin errors++; $display("FAIL b2b_timing got %0d,%0d exp %0d,%0d", g0_c[0], g0_c[1], s4 + 2, s8 + 2); end
    end
  endtask

  task automatic test_bubbles();
    int s;
    int av[4] = '{10, -20, 30, -40};
    clear_caps();
    for (int k = 0; k < 4; k++) begin put0(av[k], 1, s); idle0(2); end
    idle0(4);
    exp_hold0 = -20;
    checks++;
    if (g0_f.size() != 1) begin errors++; $display("FAIL bubble_pulses got %0d exp 1", g0_f.size()); end
    else begin
      checks++; if (g0_f[0] !== -20) begin errors++; $display("FAIL bubble_f got %0d exp -20", g0_f[0]); end
      checks++; if (g0_c[0] !== s + 2) begin errors++; $display("FAIL bubble_latency got %0d exp %0d", g0_c[0], s + 2); end
    end
  endtask

  task automatic test_clear();
    int s;
    clear_caps();
    put0(1, 1, s); put0(1, 1, s);
    @(negedge clk); a0 = 14'sd5; b0 = 14'sd5; vin0 = 1'b1; clear0 = 1'b1;
    @(negedge clk); clear0 = 1'b0; vin0 = 1'b0;
    checks++; if (longint'(f0) !== exp_hold0) begin errors++; $display("FAIL clear_hold got %0d exp %0d", f0, exp_hold0); end
    for (int k = 0; k < 4; k++) put0(2, 3, s);
    idle0(6);
    checks++;
    if (g0_f.size() != 1) begin errors++; $display("FAIL clear_pulses got %0d exp 1", g0_f.size()); end
    else begin
      checks++; if (g0_f[0] !== 24) begin errors++; $display("FAIL clear_f got %0d exp 24", g0_f[0]); end
    end
    // clear landing on the edge that would complete the vector
    clear_caps();
    for (int k = 0; k < 4; k++) put0(1, 1, s);
    idle0(1);
    @(negedge clk); clear0 = 1'b1;
    @(negedge clk); clear0 = 1'b0;
    idle0(4);
    checks++; if (g0_f.size() != 0) begin errors++; $display("FAIL clear_suppress got %0d pulses exp 0", g0_f.size()); end
    checks++; if (f0 !== 32'sd24) begin errors++; $display("FAIL clear_suppress_hold got %0d exp 24", f0); end
    for (int k = 0; k < 4; k++) put0(3, 1, s);
    idle0(6);
    checks++;
    if (g0_f.size() != 1 || g0_f[0] !== 12) begin errors++; $display("FAIL clear_after got n=%0d f=%0d exp n=1 f=12", g0_f.size(), f0); end
  endtask

  task automatic test_reset_mid();
    int s;
    put0(7, 7, s); put0(7, 7, s);
    @(negedge clk); vin0 = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (f0 !== 32'sd0) begin errors++; $display("FAIL rstmid_f got %0d exp 0", f0); end
    checks++; if (vo0 !== 1'b0 || ovf0 !== 1'b0) begin errors++; $display("FAIL rstmid_flags got v=%b o=%b exp 0/0", vo0, ovf0); end
    @(negedge clk); reset = 1'b1;
    clear_caps();
    for (int k = 0; k < 4; k++) put0(k + 1, 1, s);
    idle0(6);
    checks++;
    if (g0_f.size() != 1 || g0_f[0] !== 10) begin errors++; $display("FAIL rstmid_after got n=%0d f=%0d exp n=1 f=10", g0_f.size(), f0); end
  endtask

  task automatic test_saturation();
    int s;
    longint ef;
`ifdef MAC_VEC_SAT_EN
    ef = 134217727;
`else
    ef = 0;
`endif
    clear_caps();
    for (int k = 0; k < 4; k++) put1(-8192, -8192, s);
    idle1(6);
    checks++;
    if (g1_f.size() != 1) begin errors++; $display("FAIL sat_pulses got %0d exp 1", g1_f.size()); end
    else begin
      checks++; if (g1_f[0] !== ef) begin errors++; $display("FAIL sat_f got %0d exp %0d", g1_f[0], ef); end
      checks++; if (g1_o[0] !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b exp 1", g1_o[0]); end
    end
  endtask

  task automatic test_random();
    longint ef[$], sum;
    bit eo[$], o;
    int ec[$], s, av, bv;
    clear_caps();
    for (int v = 0; v < 12; v++) begin
      sum = 0; o = 1'b0;
      for (int k = 0; k < 4; k++) begin
        av = rnd14(); bv = rnd14();
        sum = ref_add(sum, longint'(av) * longint'(bv), 32, o);
        put0(av, bv, s); idle0(int'($urandom_range(0, 2)));
      end
      ef.push_back(sum); eo.push_back(o); ec.push_back(s + 2);
    end
    idle0(6);
    checks++; if (g0_f.size() != ef.size()) begin errors++; $display("FAIL rand0_pulses got %0d exp %0d", g0_f.size(), ef.size()); end
    for (int i = 0; i < ef.size() && i < g0_f.size(); i++) begin
      checks++;
      if (g0_f[i] !== ef[i] || g0_o[i] !== eo[i] || g0_c[i] !== ec[i])
        begin errors++; $display("FAIL rand0_vec%0d got f=%0d o=%b c=%0d exp f=%0d o=%b c=%0d", i, g0_f[i], g0_o[i], g0_c[i], ef[i], eo[i], ec[i]); end
    end
    // narrow accumulator: bias toward extreme operands to hit overflow
    ef.delete(); eo.delete(); ec.delete();
    for (int v = 0; v < 12; v++) begin
      sum = 0; o = 1'b0;
      for (int k = 0; k < 4; k++) begin
        av = (v % 2 == 1) ? (($urandom_range(0, 1) == 1) ? 8191 : -8192) : rnd14();
        bv = (v % 2 == 1) ? (($urandom_range(0, 1) == 1) ? 8191 : -8192) : rnd14();
        sum = ref_add(sum, longint'(av) * longint'(bv), 28, o);
        put1(av, bv, s); idle1(int'($urandom_range(0, 2)));
      end
      ef.push_back(sum); eo.push_back(o); ec.push_back(s + 2);
    end
    idle1(6);
    checks++; if (g1_f.size() != ef.size()) begin errors++; $display("FAIL rand1_pulses got %0d exp %0d", g1_f.size(), ef.size()); end
    for (int i = 0; i < ef.size() && i < g1_f.size(); i++) begin
      checks++;
      if (g1_f[i] !== ef[i] || g1_o[i] !== eo[i] || g1_c[i] !== ec[i])
        begin errors++; $display("FAIL rand1_vec%0d got f=%0d o=%b c=%0d exp f=%0d o=%b c=%0d", i, g1_f[i], g1_o[i], g1_c[i], ef[i], eo[i], ec[i]); end
    end
  endtask

  task automatic test_single_elem();
    longint ef[$];
    int ec[$], s, av, bv;
    clear_caps();
    for (int i = 0; i < 10; i++) begin
      av = (i == 0) ? -8192 : rnd14();
      bv = (i == 0) ? 8191 : rnd14();
      ef.push_back(longint'(av) * longint'(bv));
      put2(av, bv, s);
      ec.push_back(s + 1);
      idle2(int'($urandom_range(0, 1)));
    end
    idle2(4);
    checks++; if (g2_f.size() != ef.size()) begin errors++; $display("FAIL single_pulses got %0d exp %0d", g2_f.size(), ef.size()); end
    checks++; if (g2_f.size() > 0 && g2_f[0] !== -67100672) begin errors++; $display("FAIL single_first got %0d exp -67100672", g2_f[0]); end
    for (int i = 0; i < ef.size() && i < g2_f.size(); i++) begin
      checks++;
      if (g2_f[i] !== ef[i] || g2_o[i] !== 1'b0 || g2_c[i] !== ec[i])
        begin errors++; $display("FAIL single_%0d got f=%0d o=%b c=%0d exp f=%0d o=0 c=%0d", i, g2_f[i], g2_o[i], g2_c[i], ef[i], ec[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bubbles();
    test_clear();
    test_reset_mid();
    test_saturation();
    test_random();
    test_single_elem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
